// File: rtl/axis_cic_interp_if.sv
`default_nettype none
// ============================================================================
// Module : axis_cic_interp_if
// Input and output AXI-Stream channels of the CIC interpolator.
// Rev    : 1.0
// ============================================================================
interface axis_cic_interp_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 37
);
  logic signed [IN_WIDTH-1:0]  s_axis_data_tdata;
  logic                        s_axis_data_tvalid;
  logic                        s_axis_data_tready;
  logic signed [OUT_WIDTH-1:0] m_axis_data_tdata;
  logic                        m_axis_data_tvalid;
  logic                        m_axis_data_tready;

  modport slave (
    input  s_axis_data_tdata,
    input  s_axis_data_tvalid,
    output s_axis_data_tready,
    output m_axis_data_tdata,
    output m_axis_data_tvalid,
    input  m_axis_data_tready
  );

  modport master (
    output s_axis_data_tdata,
    output s_axis_data_tvalid,
    input  s_axis_data_tready,
    input  m_axis_data_tdata,
    input  m_axis_data_tvalid,
    output m_axis_data_tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_cic_interp.sv
`default_nettype none
// ============================================================================
// Module : axis_cic_interp
// N-stage CIC interpolator: comb at input rate, zero-stuff/ZOH upsampler, integrators.
// Rev    : 1.0
// ============================================================================
module axis_cic_interp #(
  parameter int IN_WIDTH  = 16,
  parameter int R         = 100,
  parameter int M         = 1,
  parameter int N         = 3,
  parameter int ZOH       = 0,
  parameter int OUT_WIDTH = IN_WIDTH + N*$clog2(R*M) + ZOH*$clog2(R)
) (
  input  logic             aclk,
  input  logic             arst_n,
  axis_cic_interp_if.slave axis
);
  localparam int            PW         = $clog2(R);
  localparam logic [PW-1:0] PHASE_LAST = PW'(R-1);

  logic signed [OUT_WIDTH-1:0] dly [N][M];
  logic signed [OUT_WIDTH-1:0] comb_in [N];
  logic signed [OUT_WIDTH-1:0] comb_acc;
  logic signed [OUT_WIDTH-1:0] up_data;
  logic                        up_valid;
  logic [PW-1:0]               phase;
  logic signed [OUT_WIDTH-1:0] integ [N];
  logic signed [OUT_WIDTH-1:0] upsamp;
  logic signed [OUT_WIDTH-1:0] out_next;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        en;
  logic                        last_slot;
  logic                        in_ready;
  logic                        accept;

  // comb_in[k] is the input of comb stage k+1; comb_acc ends as c_N
  always_comb begin
    comb_acc = {{(OUT_WIDTH-IN_WIDTH){axis.s_axis_data_tdata[IN_WIDTH-1]}},
                axis.s_axis_data_tdata};
    for (int k = 0; k < N; k++) begin
      comb_in[k] = comb_acc;
      comb_acc   = comb_acc - dly[k][M-1];
    end
  end

  assign last_slot = (phase == PHASE_LAST);
  assign en        = up_valid && (!out_valid || axis.m_axis_data_tready);
  // Accepting on the last slot keeps the stream gapless: one input per R outputs
  assign in_ready  = arst_n && (!up_valid || (en && last_slot));
  assign accept    = axis.s_axis_data_tvalid && in_ready;

  generate
    if (ZOH != 0) begin : g_zoh
      assign upsamp = up_data;
    end else begin : g_zero_stuff
      assign upsamp = (phase == '0) ? up_data : '0;
    end
  endgenerate

  // The output register holds the freshly updated last integrator
  generate
    if (N == 1) begin : g_out_single
      assign out_next = integ[0] + upsamp;
    end else begin : g_out_chain
      assign out_next = integ[N-1] + integ[N-2];
    end
  endgenerate

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < N; k++) begin
        integ[k] <= '0;
        for (int j = 0; j < M; j++) begin
          dly[k][j] <= '0;
        end
      end
      up_data   <= '0;
      up_valid  <= 1'b0;
      phase     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < N; k++) begin
          dly[k][0] <= comb_in[k];
          for (int j = 1; j < M; j++) begin
            dly[k][j] <= dly[k][j-1];
          end
        end
        up_data  <= comb_acc;
        up_valid <= 1'b1;
        phase    <= '0;
      end else if (en) begin
        phase <= phase + 1'b1;
        if (last_slot) begin
          up_valid <= 1'b0;
        end
      end

      if (en) begin
        integ[0] <= integ[0] + upsamp;
        for (int k = 1; k < N; k++) begin
          integ[k] <= integ[k] + integ[k-1];
        end
        out_data  <= out_next;
        out_valid <= 1'b1;
      end else if (axis.m_axis_data_tready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign axis.s_axis_data_tready = in_ready;
  assign axis.m_axis_data_tdata  = out_data;
  assign axis.m_axis_data_tvalid = out_valid;
endmodule
`default_nettype wire

// File: tb/tb_axis_cic_interp.sv
`default_nettype none
// ============================================================================
// Module : tb_axis_cic_interp
// Bench for axis_cic_interp: five configurations checked against a sequence-level model.
// Rev    : 1.0
// ============================================================================
module tb_axis_cic_interp;
  localparam int NI = 5;
  localparam int IW = 16;

  function automatic int calc_ow(input int n, input int r, input int m, input int z);
    return IW + n*$clog2(r*m) + z*$clog2(r);
  endfunction

  // 0: N1 R4 zero-stuff, 1: N1 R4 ZOH, 2: N3 R8, 3: N3 R100 (wrap), 4: N2 R5 M2 ZOH
  localparam int R0 = 4,   M0 = 1, N0 = 1, Z0 = 0;
  localparam int R1 = 4,   M1 = 1, N1 = 1, Z1 = 1;
  localparam int R2 = 8,   M2 = 1, N2 = 3, Z2 = 0;
  localparam int R3 = 100, M3 = 1, N3 = 3, Z3 = 0;
  localparam int R4 = 5,   M4 = 2, N4 = 2, Z4 = 1;
  localparam int OW0 = calc_ow(N0, R0, M0, Z0);
  localparam int OW1 = calc_ow(N1, R1, M1, Z1);
  localparam int OW2 = calc_ow(N2, R2, M2, Z2);
  localparam int OW3 = calc_ow(N3, R3, M3, Z3);
  localparam int OW4 = calc_ow(N4, R4, M4, Z4);

  typedef struct packed { int r; int m; int n; int z; int ow; } cfg_t;

  logic          aclk    = 1'b0;
  logic          arst_n  = 1'b0;
  logic [NI-1:0] s_valid = '0;
  logic [NI-1:0] m_ready = '0;
  logic [IW-1:0] s_data  = '0;

  always #5 aclk = ~aclk;

  axis_cic_interp_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW0)) bus0 ();
  assign bus0.s_axis_data_tdata  = s_data;
  assign bus0.s_axis_data_tvalid = s_valid[0];
  assign bus0.m_axis_data_tready = m_ready[0];
  axis_cic_interp #(.IN_WIDTH(IW), .R(R0), .M(M0), .N(N0), .ZOH(Z0))
    dut0 (.aclk(aclk), .arst_n(arst_n), .axis(bus0.slave));

  axis_cic_interp_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW1)) bus1 ();
  assign bus1.s_axis_data_tdata  = s_data;
  assign bus1.s_axis_data_tvalid = s_valid[1];
  assign bus1.m_axis_data_tready = m_ready[1];
  axis_cic_interp #(.IN_WIDTH(IW), .R(R1), .M(M1), .N(N1), .ZOH(Z1))
    dut1 (.aclk(aclk), .arst_n(arst_n), .axis(bus1.slave));

  axis_cic_interp_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW2)) bus2 ();
  assign bus2.s_axis_data_tdata  = s_data;
  assign bus2.s_axis_data_tvalid = s_valid[2];
  assign bus2.m_axis_data_tready = m_ready[2];
  axis_cic_interp #(.IN_WIDTH(IW), .R(R2), .M(M2), .N(N2), .ZOH(Z2))
    dut2 (.aclk(aclk), .arst_n(arst_n), .axis(bus2.slave));

  axis_cic_interp_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW3)) bus3 ();
  assign bus3.s_axis_data_tdata  = s_data;
  assign bus3.s_axis_data_tvalid = s_valid[3];
  assign bus3.m_axis_data_tready = m_ready[3];
  axis_cic_interp #(.IN_WIDTH(IW), .R(R3), .M(M3), .N(N3), .ZOH(Z3))
    dut3 (.aclk(aclk), .arst_n(arst_n), .axis(bus3.slave));

  axis_cic_interp_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW4)) bus4 ();
  assign bus4.s_axis_data_tdata  = s_data;
  assign bus4.s_axis_data_tvalid = s_valid[4];
  assign bus4.m_axis_data_tready = m_ready[4];
  axis_cic_interp #(.IN_WIDTH(IW), .R(R4), .M(M4), .N(N4), .ZOH(Z4))
    dut4 (.aclk(aclk), .arst_n(arst_n), .axis(bus4.slave));

  int           n_cmp = 0;
  int           n_bad = 0;
  longint       stim[$];
  logic [63:0]  obs[$];
  logic [63:0]  expq[$];
  int           first_acc;
  int           first_val;
  int           gap_bad;

  function automatic cfg_t cfg(input int k);
    case (k)
      0:       return '{R0, M0, N0, Z0, OW0};
      1:       return '{R1, M1, N1, Z1, OW1};
      2:       return '{R2, M2, N2, Z2, OW2};
      3:       return '{R3, M3, N3, Z3, OW3};
      default: return '{R4, M4, N4, Z4, OW4};
    endcase
  endfunction

  function automatic logic [63:0] mask(input int ow);
    return (ow >= 64) ? '1 : ((64'd1 << ow) - 64'd1);
  endfunction

  function automatic logic get_sready(input int k);
    case (k)
      0:       return bus0.s_axis_data_tready;
      1:       return bus1.s_axis_data_tready;
      2:       return bus2.s_axis_data_tready;
      3:       return bus3.s_axis_data_tready;
      default: return bus4.s_axis_data_tready;
    endcase
  endfunction

  function automatic logic get_mvalid(input int k);
    case (k)
      0:       return bus0.m_axis_data_tvalid;
      1:       return bus1.m_axis_data_tvalid;
      2:       return bus2.m_axis_data_tvalid;
      3:       return bus3.m_axis_data_tvalid;
      default: return bus4.m_axis_data_tvalid;
    endcase
  endfunction

  function automatic logic [63:0] get_mdata(input int k);
    logic [63:0] v;
    case (k)
      0:       v = 64'(bus0.m_axis_data_tdata);
      1:       v = 64'(bus1.m_axis_data_tdata);
      2:       v = 64'(bus2.m_axis_data_tdata);
      3:       v = 64'(bus3.m_axis_data_tdata);
      default: v = 64'(bus4.m_axis_data_tdata);
    endcase
    return v & mask(cfg(k).ow);
  endfunction

  // Reference: comb differences on the sample sequence, upsample to R slots each,
  // N running sums, then the N-1 slot pipeline delay of the integrator chain.
  task automatic build_model(input int k);
    cfg_t   cf;
    longint st[$];
    longint prev[$];
    longint u[$];
    longint acc;
    cf = cfg(k);
    st = stim;
    for (int s = 0; s < cf.n; s++) begin
      prev = st;
      for (int i = 0; i < st.size(); i++)
        st[i] = prev[i] - ((i >= cf.m) ? prev[i-cf.m] : 64'sd0);
    end
    u.delete();
    for (int i = 0; i < st.size(); i++)
      for (int p = 0; p < cf.r; p++)
        u.push_back((cf.z != 0 || p == 0) ? st[i] : 64'sd0);
    for (int s = 0; s < cf.n; s++) begin
      acc = 0;
      for (int i = 0; i < u.size(); i++) begin
        acc  = acc + u[i];
        u[i] = acc;
      end
    end
    expq.delete();
    for (int i = 0; i < u.size(); i++)
      expq.push_back(64'((i >= cf.n-1) ? u[i-(cf.n-1)] : 64'sd0) & mask(cf.ow));
  endtask

  task automatic do_reset();
    s_valid = '0;
    m_ready = '0;
    @(negedge aclk);
    arst_n = 1'b0;
    repeat (3) @(negedge aclk);
    arst_n = 1'b1;
  endtask

  // Streams stim into instance k with given valid/ready percentages and collects
  // every transferred output; also checks output stability while stalled.
  task automatic run_stream(input int k, input int vpct, input int rpct);
    cfg_t        cf;
    int          idx;
    int          cyc;
    int          prev_acc;
    int          target;
    logic        hold_pending;
    logic [63:0] hold_val;
    cf = cfg(k);
    idx = 0; cyc = 0; prev_acc = -1;
    target = stim.size() * cf.r;
    hold_pending = 1'b0; hold_val = '0;
    obs.delete();
    first_acc = -1; first_val = -1; gap_bad = 0;
    while (obs.size() < target && cyc < target*10 + 100) begin
      @(negedge aclk);
      m_ready[k] = ($urandom_range(99) < rpct);
      s_valid[k] = (idx < stim.size()) && ($urandom_range(99) < vpct);
      s_data     = (idx < stim.size()) ? IW'(stim[idx]) : IW'($urandom);
      #1;
      if (hold_pending) begin
        n_cmp++;
        if (get_mvalid(k) !== 1'b1 || get_mdata(k) !== hold_val) begin
          n_bad++;
          $display("FAIL stall_hold[k%0d cyc %0d]: valid=%0b data=%0h, required valid=1 data=%0h",
                   k, cyc, get_mvalid(k), get_mdata(k), hold_val);
        end
      end
      if (s_valid[k] && get_sready(k)) begin
        if (first_acc < 0) first_acc = cyc;
        if (prev_acc >= 0 && cyc - prev_acc != cf.r) gap_bad++;
        prev_acc = cyc;
        idx++;
      end
      if (get_mvalid(k) && first_val < 0) first_val = cyc;
      if (get_mvalid(k) && m_ready[k]) obs.push_back(get_mdata(k));
      hold_pending = get_mvalid(k) && !m_ready[k];
      hold_val     = get_mdata(k);
      cyc++;
    end
    s_valid[k] = 1'b0;
    m_ready[k] = 1'b0;
    n_cmp++;
    if (obs.size() < target) begin
      n_bad++;
      $display("FAIL stream_timeout[k%0d]: got %0d outputs, required %0d", k, obs.size(), target);
    end
  endtask

  task automatic load_impulse(input int len);
    stim.delete();
    stim.push_back(100);
    for (int i = 1; i < len; i++) stim.push_back(0);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (get_mvalid(k) !== 1'b0 || get_mdata(k) !== 64'd0 || get_sready(k) !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state[k%0d]: mvalid=%0b mdata=%0h sready=%0b, required 0/0/0",
                 k, get_mvalid(k), get_mdata(k), get_sready(k));
      end
    end
    @(negedge aclk);
    arst_n = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (get_sready(k) !== 1'b1 || get_mvalid(k) !== 1'b0) begin
        n_bad++;
        $display("FAIL after_reset[k%0d]: sready=%0b mvalid=%0b, required 1/0",
                 k, get_sready(k), get_mvalid(k));
      end
    end
  endtask

  task automatic test_impulse_zero_stuff();
    logic [63:0] e;
    do_reset();
    load_impulse(6);
    run_stream(0, 100, 100);
    for (int i = 0; i < obs.size(); i++) begin
      e = (i < 4) ? 64'd100 : 64'd0;
      n_cmp++;
      if (obs[i] !== e) begin
        n_bad++;
        $display("FAIL impulse_zs[%0d]: got %0d, required %0d", i, obs[i], e);
      end
    end
    n_cmp++;
    if (first_val - first_acc != 2) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles, required 2", first_val - first_acc);
    end
    n_cmp++;
    if (gap_bad != 0) begin
      n_bad++;
      $display("FAIL accept_spacing: %0d accepts not R apart, required 0", gap_bad);
    end
  endtask

  task automatic test_impulse_zoh();
    int          ref_v [8];
    logic [63:0] e;
    ref_v = '{100, 200, 300, 400, 300, 200, 100, 0};
    do_reset();
    load_impulse(4);
    run_stream(1, 100, 100);
    for (int i = 0; i < obs.size(); i++) begin
      e = (i < 8) ? 64'(ref_v[i]) : 64'd0;
      n_cmp++;
      if (obs[i] !== e) begin
        n_bad++;
        $display("FAIL impulse_zoh[%0d]: got %0d, required %0d", i, obs[i], e);
      end
    end
  endtask

  task automatic test_dc_gain();
    do_reset();
    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back(10);
    run_stream(2, 100, 100);
    for (int i = 40; i < obs.size(); i++) begin
      n_cmp++;
      if (obs[i] !== 64'd640) begin
        n_bad++;
        $display("FAIL dc_gain[%0d]: got %0d, required 640", i, obs[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    do_reset();
    load_impulse(6);
    run_stream(0, 100, 50);
    for (int i = 0; i < obs.size(); i++) begin
      e = (i < 4) ? 64'd100 : 64'd0;
      n_cmp++;
      if (obs[i] !== e) begin
        n_bad++;
        $display("FAIL backpressure[%0d]: got %0d, required %0d", i, obs[i], e);
      end
    end
  endtask

  task automatic test_random_streams();
    int               ks [3];
    logic signed [15:0] t;
    ks = '{0, 4, 2};
    foreach (ks[j]) begin
      do_reset();
      stim.delete();
      for (int i = 0; i < 24; i++) begin
        t = 16'($urandom);
        stim.push_back(longint'(t));
      end
      run_stream(ks[j], 70, 50);
      build_model(ks[j]);
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
        n_cmp++;
        if (obs[i] !== expq[i]) begin
          n_bad++;
          $display("FAIL random[k%0d][%0d]: got %0h, required %0h", ks[j], i, obs[i], expq[i]);
        end
      end
    end
  endtask

  task automatic test_wrap_sine();
    longint peak;
    longint sv;
    do_reset();
    stim.delete();
    for (int i = 0; i < 64; i++)
      stim.push_back(longint'($rtoi(32767.0 * $sin(2.0 * 3.14159265358979 * i / 32.0))));
    run_stream(3, 100, 100);
    build_model(3);
    peak = 0;
    for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
      n_cmp++;
      if (obs[i] !== expq[i]) begin
        n_bad++;
        $display("FAIL wrap_sine[%0d]: got %0h, required %0h", i, obs[i], expq[i]);
      end
      sv = longint'(obs[i]);
      if (obs[i][OW3-1]) sv = sv - (64'sd1 <<< OW3);
      if (sv > peak) peak = sv;
    end
    n_cmp++;
    if (peak > 64'sd327670000 || peak < 64'sd311286500) begin
      n_bad++;
      $display("FAIL sine_peak: got %0d, required 311286500..327670000", peak);
    end
  endtask

  task automatic test_reset_midstream();
    int          slots;
    logic [63:0] e;
    do_reset();
    @(negedge aclk);
    s_data = 16'sd100; s_valid[0] = 1'b1; m_ready[0] = 1'b1;
    @(negedge aclk);
    s_valid[0] = 1'b0; s_data = '0;
    slots = 0;
    for (int c = 0; c < 20 && slots < 3; c++) begin
      @(negedge aclk);
      #1;
      if (get_mvalid(0)) slots++;
    end
    n_cmp++;
    if (slots != 3 || get_mdata(0) !== 64'd100) begin
      n_bad++;
      $display("FAIL midstream_slot3: slots=%0d data=%0d, required 3/100", slots, get_mdata(0));
    end
    #1;
    arst_n = 1'b0;
    #1;
    n_cmp++;
    if (get_mvalid(0) !== 1'b0 || get_mdata(0) !== 64'd0) begin
      n_bad++;
      $display("FAIL midstream_reset: mvalid=%0b mdata=%0d, required 0/0", get_mvalid(0), get_mdata(0));
    end
    m_ready[0] = 1'b0;
    @(negedge aclk);
    arst_n = 1'b1;
    load_impulse(6);
    run_stream(0, 100, 100);
    for (int i = 0; i < obs.size(); i++) begin
      e = (i < 4) ? 64'd100 : 64'd0;
      n_cmp++;
      if (obs[i] !== e) begin
        n_bad++;
        $display("FAIL post_reset_impulse[%0d]: got %0d, required %0d", i, obs[i], e);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge aclk);
    test_reset();
    test_impulse_zero_stuff();
    test_impulse_zoh();
    test_dc_gain();
    test_backpressure();
    test_random_streams();
    test_wrap_sine();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/axis_cic_interp.md
Name: axis_cic_interp

Overview:
- Parametrised N-stage CIC interpolator with AXI-Stream input and output, and selectable upsampler mode: zero-stuff or zero-order hold.
- Generalises the single-stage comb -> ZOH -> integrator chain to N stages and differential delay M.
- Adds downstream backpressure (m_axis_data_tready) and an input-rate ready handshake.
- Sits between axis_sin_gen (or any low-rate sample source) and the delta-sigma modulator at full clock rate.

Parameters:
- IN_WIDTH, 16, signed input sample width.
- R, 100, interpolation ratio; legal range 2..4096.
- M, 1, comb differential delay; legal values 1 or 2.
- N, 3, number of comb stages and number of integrator stages; legal range 1..6.
- ZOH, 0, upsampler mode: 0 = zero-stuff, 1 = zero-order hold.
- OUT_WIDTH, IN_WIDTH + N*$clog2(R*M) + ZOH*$clog2(R), width of the internal path and the output; derived, do not override.

Ports:
- aclk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- s_axis_data_tdata  in  IN_WIDTH  signed input sample.
- s_axis_data_tvalid  in  1  input valid.
- s_axis_data_tready  out  1  input ready; high at most once per R output slots in steady state.
- m_axis_data_tdata  out  OUT_WIDTH  signed output sample.
- m_axis_data_tvalid  out  1  output valid.
- m_axis_data_tready  in  1  downstream ready.

Behaviour:
- Reset (asynchronous, arst_n low) clears all of the following:
  - comb delay registers, hold register up_data, up_valid, phase counter, integrators I_1..I_N;
  - m_axis_data_tvalid = 0, m_axis_data_tdata = 0, s_axis_data_tready = 0 while arst_n is low.
- Reset mid-stream discards all state. The first sample after release starts from zero history.
- Arithmetic:
  - Input is sign-extended to OUT_WIDTH.
  - All adds and subtracts are two's-complement and wrap modulo 2^OUT_WIDTH. No saturation; wrap is required for CIC correctness.
- Comb section (input rate):
  - On accept (s_tvalid && s_tready), compute combinationally c_0 = x and c_k = c_{k-1} - d_k[M], where d_k[M] is c_{k-1} delayed M accepts.
  - Shift the delay lines, load up_data <= c_N, set up_valid <= 1, phase <= 0.
- Enable: en = up_valid && (!m_tvalid || m_tready).
- Upsampler output u:
  - ZOH=0: u = (phase==0) ? up_data : 0.
  - ZOH=1: u = up_data.
- On en:
  - I_1 <= I_1 + u; I_k <= I_k + I_{k-1}, using old values. This is a pipelined chain: stage k sees the input k-1 enables later.
  - m_tdata <= I_N + I_{N-1}, using old values for N>=2; for N=1, m_tdata <= I_1 + u. This equals the new I_N.
  - m_tvalid <= 1; phase <= phase + 1.
  - When phase == R-1 and no new accept occurs, up_valid <= 0.
- When en = 0 and m_tready = 1: m_tvalid <= 0.
- s_axis_data_tready = !up_valid || (en && phase == R-1). Accept and last-slot consumption in the same cycle gives gapless streaming: exactly one input per R outputs.
- Latency: input accepted at edge t -> up_valid at t+1 -> first output with m_tvalid high at t+2, assuming downstream is ready. The impulse reaches the output after N-1 further output slots.
- Backpressure: while m_tvalid && !m_tready, tdata, tvalid, phase and integrators hold. No sample is lost or duplicated.
- Starvation: if the input stalls after the last slot, up_valid = 0 and m_tvalid drops. Integrators keep their values; no zeros are inserted.
- DC gain:
  - ZOH=0: (R*M)^N / R.
  - ZOH=1: (R*M)^N.

Test Plan:
- N=1, M=1, R=4, ZOH=0; input impulse 100 then zeros, tready=1 -> output 100,100,100,100,0,0,... with one input accepted every 4 cycles.
- N=1, R=4, ZOH=1; same impulse -> output 100,200,300,400,300,200,100,0,0.
- N=3, R=8, ZOH=0; constant input 10 for 40 samples -> output settles at 10*8^3/8 = 640 and stays there exactly.
- Backpressure: random m_tready at 50% duty, same stimulus as the first scenario -> the accepted output sequence is identical to the first scenario. tdata is stable while tvalid && !tready.
- Wrap: IN_WIDTH=16, N=3, R=100; sine from axis_sin_gen at full scale for 2 periods -> output peak ≈ 32767*10^4 with no spurious jumps, and output equals the bit-accurate model despite internal integrator overflow.
- Reset mid-operation: assert arst_n=0 during the 3rd output slot -> m_tvalid=0 and tdata=0 immediately. After release, the first impulse reproduces the first scenario exactly.
